polar_crc_encoder_param: RTL and testbench

Parametrised, handshaked successor to the fixed 24-bit/64-bit CRC-aided polar encoder.
- Accepts a K-bit message on a valid/ready interface and computes a serial CRC over it.
- Maps {message, CRC} onto the information positions set by a mask parameter.
- Runs the N-point polar transform one butterfly stage per cycle, then holds the codeword until the consumer accepts it.
- Sits between the frame source and the modulator/channel model in the encode chain.

---
 rtl/polar_crc_encoder_param.sv | 190 +++++++++++++++++++
 tb/tb_polar_crc_encoder_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_crc_encoder_param.sv
// CRC-aided polar encoder: serial CRC over a K-bit message, info-set mapping,
// then an N-point polar transform run one butterfly stage per cycle.
module polar_crc_encoder_param #(
  parameter int                    LOG2N     = 6,
  parameter int                    K         = 24,
  parameter int                    CRC_W     = 16,
  parameter logic [CRC_W-1:0]      CRC_POLY  = 16'h1021,
  parameter logic [CRC_W-1:0]      CRC_INIT  = 16'hFFFF,
  parameter logic [(1<<LOG2N)-1:0] INFO_MASK = {{40{1'b1}}, {24{1'b0}}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [K-1:0]            data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<LOG2N)-1:0]   codeword,
  output logic                    busy
);

  localparam int N     = 1 << LOG2N;
  localparam int M     = K + CRC_W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CRC   = 3'd1,
    S_LOAD  = 3'd2,
    S_XFORM = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  function automatic int popcount(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // Elaboration guard: the info set must hold exactly message plus CRC bits.
  if (popcount(INFO_MASK) != M) begin : g_mask_check
    $fatal(1, "INFO_MASK popcount must equal K+CRC_W");
  end

  // Bit i is set when index i has bit t clear, i.e. is the upper leg of a stage-t butterfly.
  function automatic logic [N-1:0] stage_mask(input int t);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m = {(((i >> t) & 1) == 0), m[N-1:1]};
    return m;
  endfunction

  function automatic logic [N-1:0] xform_stage(input logic [N-1:0] x, input logic [STG_W-1:0] s);
    logic [N-1:0] r;
    r = x;
    for (int t = 0; t < LOG2N; t++) begin
      if (s == t[STG_W-1:0]) r = x ^ ((x >> (1 << t)) & stage_mask(t));
    end
    return r;
  endfunction

  // Walk u from the top index down, feeding masked slots from m's MSB onward.
  function automatic logic [N-1:0] map_info(input logic [M-1:0] m);
    logic [N-1:0] u;
    logic [M-1:0] mm;
    u  = '0;
    mm = m;
    for (int i = N - 1; i >= 0; i--) begin
      if (INFO_MASK[i]) begin
        u[i] = mm[M-1];
        mm   = mm << 1;
      end
    end
    return u;
  endfunction

  state_t             state_r, state_s;
  logic [K-1:0]       data_r;
  logic [CRC_W-1:0]   crc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [STG_W-1:0]   stg_r;
  logic [N-1:0]       x_r;
  logic [N-1:0]       codeword_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               in_ready_r;

  logic               accept_s;
  logic               done_s;
  logic               last_bit_s;
  logic               last_stg_s;
  logic               crc_fb_s;
  logic [CRC_W-1:0]   crc_nxt_s;
  logic [N-1:0]       x_nxt_s;

  assign accept_s   = in_valid && in_ready_r;
  assign done_s     = out_valid_r && out_ready;
  assign last_bit_s = (cnt_r == {CNT_W{1'b0}});
  assign last_stg_s = (stg_r == STG_W'(LOG2N - 1));
  assign crc_fb_s   = crc_r[CRC_W-1] ^ data_r[cnt_r];
  assign crc_nxt_s  = (crc_r << 1) ^ (crc_fb_s ? CRC_POLY : {CRC_W{1'b0}});
  assign x_nxt_s    = xform_stage(x_r, stg_r);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign codeword  = codeword_r;
  assign busy      = busy_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_CRC;
        else          state_s = S_IDLE;
      end
      S_CRC: begin
        if (last_bit_s) state_s = S_LOAD;
        else            state_s = S_CRC;
      end
      S_LOAD:  state_s = S_XFORM;
      S_XFORM: begin
        if (last_stg_s) state_s = S_OUT;
        else            state_s = S_XFORM;
      end
      S_OUT: begin
        if (done_s) state_s = S_IDLE;
        else        state_s = S_OUT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r      <= '0;
      crc_r       <= '0;
      cnt_r       <= '0;
      stg_r       <= '0;
      x_r         <= '0;
      codeword_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      in_ready_r <= (state_s == S_IDLE);
      busy_r     <= (state_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            data_r <= data_in;
            crc_r  <= CRC_INIT;
            cnt_r  <= CNT_W'(K - 1);
          end
        end
        S_CRC: begin
          crc_r <= crc_nxt_s;
          if (!last_bit_s) cnt_r <= cnt_r - CNT_W'(1);
        end
        S_LOAD: begin
          x_r   <= map_info({data_r, crc_r});
          stg_r <= '0;
        end
        S_XFORM: begin
          x_r <= x_nxt_s;
          if (last_stg_s) begin
            codeword_r  <= x_nxt_s;
            out_valid_r <= 1'b1;
          end else begin
            stg_r <= stg_r + STG_W'(1);
          end
        end
        S_OUT: begin
          if (done_s) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_crc_encoder_param.sv
// Randomized self-checking bench for polar_crc_encoder_param against a
// set-theoretic reference model (serial CRC, mask mapping, superset XOR).
module tb_polar_crc_encoder_param;

  localparam logic [63:0] MASK_DEF = 64'hFFFF_FFFF_FF00_0000;
  localparam logic [63:0] MASK_K1  = 64'h8000_0000_0000_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv0, ir0, ov0, or0, bz0;
  logic [23:0] di0;
  logic [63:0] cw0;
  logic        iv1, ir1, ov1, or1, bz1;
  logic [23:0] di1;
  logic [63:0] cw1;
  logic        iv2, ir2, ov2, or2, bz2;
  logic [0:0]  di2;
  logic [63:0] cw2;

  int checks = 0;
  int errors = 0;

  polar_crc_encoder_param u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .data_in(di0),
    .out_valid(ov0), .out_ready(or0), .codeword(cw0), .busy(bz0));

  polar_crc_encoder_param #(.CRC_INIT(16'h0000)) u_zero (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .data_in(di1),
    .out_valid(ov1), .out_ready(or1), .codeword(cw1), .busy(bz1));

  polar_crc_encoder_param #(.K(1), .CRC_INIT(16'h0000), .INFO_MASK(MASK_K1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .data_in(di2),
    .out_valid(ov2), .out_ready(or2), .codeword(cw2), .busy(bz2));

  // Reference: CRC-16 (poly 1021) serially, u from mask order, x[i] = XOR of u[j] for j superset of i.
  function automatic logic [63:0] golden(input int k, input logic [23:0] msg,
                                         input logic [15:0] init, input logic [63:0] mask);
    logic [15:0] crc;
    logic        fb;
    logic        q[$];
    logic [63:0] u, x;
    int          p;
    crc = init;
    for (int b = k - 1; b >= 0; b--) begin
      fb  = crc[15] ^ msg[b];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    for (int b = k - 1; b >= 0; b--) q.push_back(msg[b]);
    for (int b = 15; b >= 0; b--) q.push_back(crc[b]);
    u = '0;
    p = 0;
    for (int i = 63; i >= 0; i--) begin
      if (mask[i]) begin
        u[i] = q[p];
        p++;
      end
    end
    x = '0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        if ((j & i) == i) x[i] = x[i] ^ u[j];
    return x;
  endfunction

  // Offer one message to u_def; returns at the negedge right after the accepting edge.
  task automatic start0(input logic [23:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (ir0 !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    iv0 = 1'b1;
    di0 = d;
    @(negedge clk);
    iv0 = 1'b0;
    di0 = 24'($urandom);
  endtask

  task automatic wait_ov0(output int lat);
    lat = 0;
    while (ov0 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv0 = 1'b0; or0 = 1'b0; di0 = '0;
    iv1 = 1'b0; or1 = 1'b0; di1 = '0;
    iv2 = 1'b0; or2 = 1'b0; di2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", ir0); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov0); end
    checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bz0); end
    checks++; if (cw0 !== 64'h0) begin errors++; $display("FAIL reset_codeword: got %h expected 0", cw0); end
    checks++; if (ir1 !== 1'b1 || ir2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_others: got %b%b expected 11", ir1, ir2); end
  endtask

  task automatic test_zero_msg();
    int  lat;
    bit  ready_low;
    @(negedge clk);
    or1 = 1'b1; iv1 = 1'b1; di1 = 24'h000000;
    @(negedge clk);
    iv1 = 1'b0; di1 = 24'hABCDEF;
    checks++; if (bz1 !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", bz1); end
    lat = 0; ready_low = 1'b1;
    while (ov1 !== 1'b1 && lat < 200) begin
      if (ir1 !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 31) begin errors++; $display("FAIL zero_latency: got %0d expected 31", lat); end
    checks++; if (cw1 !== 64'h0) begin errors++; $display("FAIL zero_codeword: got %h expected 0", cw1); end
    checks++; if (!ready_low || ir1 !== 1'b0) begin errors++; $display("FAIL zero_in_ready_busy: got %b expected 0 throughout", ir1); end
    @(negedge clk);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL zero_pulse: got %b expected 0", ov1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL zero_in_ready_after: got %b expected 1", ir1); end
    or1 = 1'b0;
  endtask

  task automatic test_k1();
    int          lat;
    logic [63:0] exp;
    exp = golden(1, 24'h000001, 16'h0000, MASK_K1);
    @(negedge clk);
    or2 = 1'b1; iv2 = 1'b1; di2 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0; di2 = 1'b0;
    lat = 0;
    while (ov2 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL k1_latency: got %0d expected 8", lat); end
    checks++; if (cw2 !== exp) begin errors++; $display("FAIL k1_codeword: got %h expected %h", cw2, exp); end
    @(negedge clk);
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL k1_pulse: got %b expected 0", ov2); end
    or2 = 1'b0;
  endtask

  task automatic test_random();
    int          lat, st;
    logic [23:0] d;
    logic [63:0] exp;
    bit          pre;
    for (int n = 0; n < 1000; n++) begin
      d   = 24'($urandom);
      exp = golden(24, d, 16'hFFFF, MASK_DEF);
      pre = 1'($urandom_range(0, 1));
      or0 = pre;
      start0(d);
      wait_ov0(lat);
      checks++; if (lat !== 31) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 31", n, lat); end
      checks++; if (cw0 !== exp) begin errors++; $display("FAIL rand_codeword[%0d]: msg %h got %h expected %h", n, d, cw0, exp); end
      if (!pre) begin
        st = $urandom_range(1, 4);
        for (int c = 0; c < st; c++) begin
          @(negedge clk);
          checks++;
          if (ov0 !== 1'b1 || cw0 !== exp) begin
            errors++; $display("FAIL rand_stall[%0d]: valid %b cw %h expected 1 %h", n, ov0, cw0, exp);
          end
        end
        or0 = 1'b1;
      end
      @(negedge clk);
      checks++; if (ov0 !== 1'b0 || cw0 !== exp) begin errors++; $display("FAIL rand_after_hs[%0d]: valid %b cw %h expected 0 %h", n, ov0, cw0, exp); end
      or0 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [23:0] d;
    logic [63:0] exp;
    bit          quiet;
    d   = 24'($urandom);
    exp = golden(24, d, 16'hFFFF, MASK_DEF);
    or0 = 1'b0;
    start0(d);
    wait_ov0(lat);
    checks++; if (lat !== 31) begin errors++; $display("FAIL bp_latency: got %0d expected 31", lat); end
    for (int c = 0; c < 20; c++) begin
      iv0 = 1'($urandom_range(0, 1));
      di0 = 24'($urandom);
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b1 || cw0 !== exp) begin
        errors++; $display("FAIL bp_hold[%0d]: valid %b cw %h expected 1 %h", c, ov0, cw0, exp);
      end
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    checks++; if (ov0 !== 1'b0 || ir0 !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b expected 0 1", ov0, ir0); end
    quiet = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov0 !== 1'b0 || bz0 !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL bp_no_extra_frame: valid %b busy %b expected 0 0", ov0, bz0); end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [23:0] d;
    logic [63:0] exp;
    bit          quiet;
    d = 24'($urandom);
    or0 = 1'b1;
    start0(d);
    repeat (27) @(negedge clk);
    checks++; if (bz0 !== 1'b1 || ov0 !== 1'b0) begin errors++; $display("FAIL mid_in_xform: busy %b valid %b expected 1 0", bz0, ov0); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bz0 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: busy %b valid %b expected 0 0", bz0, ov0); end
    quiet = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov0 !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL mid_discard: out_valid got 1 expected 0"); end
    d   = 24'($urandom);
    exp = golden(24, d, 16'hFFFF, MASK_DEF);
    start0(d);
    wait_ov0(lat);
    checks++; if (lat !== 31) begin errors++; $display("FAIL mid_next_latency: got %0d expected 31", lat); end
    checks++; if (cw0 !== exp) begin errors++; $display("FAIL mid_next_codeword: got %h expected %h", cw0, exp); end
    @(negedge clk);
    or0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_msg();
    test_k1();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
